// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 byte-bus framer packing RGB565 pixels into a FIFO write port.
// Optional dropped-pixel counter enabled by defining OV7670_CAPTURE_DROP_CNT_EN.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 11
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_vsync,
    input  logic          i_href,
    input  logic [7:0]    i_data,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_full,
    output logic          o_wr,
    output logic [15:0]   o_data,
    output logic          o_sof,
    output logic          o_eof,
    output logic          o_overflow,
    output logic          o_line_err,
    output logic          o_frame_err,
    output logic [CW-1:0] o_line_cnt,
    output logic [15:0]   o_drop_cnt
);

    typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE, S_SKIP} state_t;

    localparam logic [CW-1:0] H_EXP = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_EXP = CW'(V_ACTIVE);

    state_t        state_q, state_d;
    logic          vsync_q, href_q;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic          wr_q, wr_d;
    logic [15:0]   data_q, data_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          overflow_q, overflow_d;
    logic          line_err_q, line_err_d;
    logic          frame_err_q, frame_err_d;

    logic          vs_rise, vs_fall, href_fall;
    logic          line_done;
    logic [CW-1:0] line_cnt_nxt;

    assign vs_rise   = i_vsync & ~vsync_q;
    assign vs_fall   = ~i_vsync & vsync_q;
    assign href_fall = ~i_href & href_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        wr_d         = 1'b0;
        data_d       = data_q;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        overflow_d   = overflow_q & ~i_clr;
        line_err_d   = line_err_q & ~i_clr;
        frame_err_d  = frame_err_q & ~i_clr;
        line_done    = 1'b0;
        line_cnt_nxt = line_cnt_q;

        case (state_q)
            S_SYNC: begin
                if (i_vsync) state_d = S_VBLANK;
            end
            S_VBLANK: begin
                if (vs_fall) begin
                    if (i_en) begin
                        state_d    = S_ACTIVE;
                        sof_d      = 1'b1;
                        line_cnt_d = '0;
                        phase_d    = 1'b0;
                        pix_cnt_d  = '0;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (vs_rise) state_d = S_VBLANK;
            end
            S_ACTIVE: begin
                // A line still open when vsync rises is closed in the same cycle.
                line_done = vs_rise ? href_q : href_fall;

                if (!vs_rise && i_href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = i_data;
                    end else begin
                        if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
                        if (i_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = {hi_q, i_data};
                        end
                    end
                end

                if (line_done) begin
                    if (line_cnt_q != '1) line_cnt_nxt = line_cnt_q + 1'b1;
                    line_cnt_d = line_cnt_nxt;
                    if (phase_q || (pix_cnt_q != H_EXP)) line_err_d = 1'b1;
                    phase_d   = 1'b0;
                    pix_cnt_d = '0;
                end

                if (vs_rise) begin
                    eof_d   = 1'b1;
                    state_d = S_VBLANK;
                    if (line_cnt_nxt != V_EXP) frame_err_d = 1'b1;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_SYNC;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= 8'd0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            wr_q        <= 1'b0;
            data_q      <= 16'd0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            overflow_q  <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= i_vsync;
            href_q      <= i_href;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            overflow_q  <= overflow_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef OV7670_CAPTURE_DROP_CNT_EN
    logic        drop_evt;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_evt = (state_q == S_ACTIVE) && !vs_rise && i_href && phase_q && i_full;

    // A drop coinciding with a clear leaves the count at one.
    always_comb begin
        drop_cnt_d = i_clr ? 16'd0 : drop_cnt_q;
        if (drop_evt && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) drop_cnt_q <= 16'd0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = 16'd0;
`endif

    assign o_wr        = wr_q;
    assign o_data      = data_q;
    assign o_sof       = sof_q;
    assign o_eof       = eof_q;
    assign o_overflow  = overflow_q;
    assign o_line_err  = line_err_q;
    assign o_frame_err = frame_err_q;
    assign o_line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - self-checking bench for ov7670_capture against a frame-level model.
module tb_ov7670_capture;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n, vsync, href, en, clr, full;
    logic [7:0]    data;
    logic          o_wr, o_sof, o_eof, o_overflow, o_line_err, o_frame_err;
    logic [15:0]   o_data, o_drop_cnt;
    logic [CW-1:0] o_line_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_vsync(vsync), .i_href(href), .i_data(data),
        .i_en(en), .i_clr(clr), .i_full(full), .o_wr(o_wr), .o_data(o_data),
        .o_sof(o_sof), .o_eof(o_eof), .o_overflow(o_overflow), .o_line_err(o_line_err),
        .o_frame_err(o_frame_err), .o_line_cnt(o_line_cnt), .o_drop_cnt(o_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int sof_cnt = 0;
    int eof_cnt = 0;

    always @(negedge clk) begin
        if (o_wr)  got_q.push_back(o_data);
        if (o_sof) sof_cnt++;
        if (o_eof) eof_cnt++;
    end

    int            line_len[8];
    bit            full_pix[8][8];
    bit            exp_over, exp_lerr, exp_ferr;
    int            exp_drops, exp_sof, exp_eof;
    logic [CW-1:0] exp_lines;

    function automatic logic [15:0] exp_drop_cnt();
`ifdef OV7670_CAPTURE_DROP_CNT_EN
        return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
        return 16'd0;
`endif
    endfunction

    task automatic set_lines(input int n, input int len);
        for (int i = 0; i < 8; i++) begin
            line_len[i] = (i < n) ? len : 0;
            for (int j = 0; j < 8; j++) full_pix[i][j] = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_over = 0; exp_lerr = 0; exp_ferr = 0; exp_drops = 0;
        exp_sof = 0; exp_eof = 0; exp_lines = '0;
        exp_q.delete(); got_q.delete(); sof_cnt = 0; eof_cnt = 0;
    endtask

    task automatic run_frame(input int nlines, input bit en_sof, input bit en_drop, input bit rnd);
        logic [7:0] b0, bv;
        int np;
        b0 = 8'd0;
        @(negedge clk); vsync = 1'b1; href = 1'b0; en = en_sof; full = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk); if (en_drop) en = 1'b0;
        @(negedge clk);
        if (en_sof) begin exp_sof++; exp_lines = '0; end
        for (int l = 0; l < nlines; l++) begin
            np = 0;
            for (int b = 0; b < line_len[l]; b++) begin
                @(negedge clk);
                bv = rnd ? 8'($urandom) : 8'(b);
                href = 1'b1; data = bv;
                if (b % 2 == 0) begin
                    b0 = bv; full = 1'($urandom);
                end else begin
                    full = full_pix[l][b/2];
                    np++;
                    if (en_sof) begin
                        if (full) begin exp_over = 1; exp_drops++; end
                        else exp_q.push_back({b0, bv});
                    end
                end
            end
            @(negedge clk); href = 1'b0; full = 1'b0;
            if (en_sof) begin
                if ((line_len[l] % 2 != 0) || (np != H)) exp_lerr = 1;
                exp_lines = exp_lines + 1'b1;
            end
            repeat (2) @(negedge clk);
        end
        vsync = 1'b1;
        if (en_sof) begin exp_eof++; if (nlines != V) exp_ferr = 1; end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string name);
        chk({name, " writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s pix%0d", name, i), got_q[i], exp_q[i]);
        chk({name, " sof"}, sof_cnt, exp_sof);
        chk({name, " eof"}, eof_cnt, exp_eof);
        chk({name, " line_cnt"}, o_line_cnt, exp_lines);
        chk({name, " overflow"}, o_overflow, exp_over);
        chk({name, " line_err"}, o_line_err, exp_lerr);
        chk({name, " frame_err"}, o_frame_err, exp_ferr);
        chk({name, " drop_cnt"}, o_drop_cnt, exp_drop_cnt());
        got_q.delete(); exp_q.delete();
        sof_cnt = 0; eof_cnt = 0; exp_sof = 0; exp_eof = 0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        exp_over = 0; exp_lerr = 0; exp_ferr = 0; exp_drops = 0;
        @(negedge clk);
    endtask

    initial begin
        int nl;
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'd0;
        en = 1'b1; clr = 1'b0; full = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst o_wr", o_wr, 1'b0);
        chk("rst o_data", o_data, 16'h0000);
        chk("rst o_sof", o_sof, 1'b0);
        chk("rst o_eof", o_eof, 1'b0);
        chk("rst overflow", o_overflow, 1'b0);
        chk("rst line_err", o_line_err, 1'b0);
        chk("rst frame_err", o_frame_err, 1'b0);
        chk("rst line_cnt", o_line_cnt, 11'd0);
        chk("rst drop_cnt", o_drop_cnt, 16'h0000);

        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); href = ~href; data = 8'($urandom);
        end
        href = 1'b0;
        chk("post-rst writes", got_q.size(), 0);
        chk("post-rst sof", sof_cnt, 0);

        set_lines(3, 8);
        run_frame(3, 1'b1, 1'b0, 1'b0);
        chk("nominal count", got_q.size(), 12);
        check_frame("nominal");

        set_lines(3, 8);
        full_pix[0][1] = 1'b1; full_pix[0][2] = 1'b1;
        run_frame(3, 1'b1, 1'b0, 1'b1);
        chk("backpressure count", got_q.size(), 10);
        check_frame("backpressure");
        pulse_clr();
        check_frame("bp clr");

        set_lines(3, 8);
        line_len[1] = 7;
        run_frame(3, 1'b1, 1'b0, 1'b1);
        chk("odd line count", got_q.size(), 11);
        check_frame("odd line");
        pulse_clr();
        check_frame("odd clr");

        set_lines(3, 8);
        run_frame(3, 1'b0, 1'b0, 1'b1);
        check_frame("en low at sof");

        run_frame(3, 1'b1, 1'b1, 1'b1);
        chk("en drop count", got_q.size(), 12);
        check_frame("en drop mid");

        set_lines(2, 8);
        run_frame(2, 1'b1, 1'b0, 1'b1);
        check_frame("short frame");
        pulse_clr();

        for (int f = 0; f < 6; f++) begin
            nl = $urandom_range(2, 4);
            set_lines(nl, 8);
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(0, 4))
                    0: line_len[l] = 7;
                    1: line_len[l] = 6;
                    2: line_len[l] = 10;
                    default: line_len[l] = 8;
                endcase
                for (int p = 0; p < 8; p++) full_pix[l][p] = ($urandom_range(0, 3) == 0);
            end
            run_frame(nl, ($urandom_range(0, 4) != 0), 1'b0, 1'b1);
            check_frame($sformatf("random%0d", f));
            if (f % 2 == 1) pulse_clr();
        end

        @(negedge clk); vsync = 1'b1; href = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        href = 1'b1; data = 8'hAA; full = 1'b0;
        @(negedge clk); data = 8'hBB;
        @(posedge clk); #1;
        chk("pre-arst o_wr", o_wr, 1'b1);
        chk("pre-arst o_data", o_data, 16'hAABB);
        #1 rst_n = 1'b0;
        #1;
        chk("arst o_wr", o_wr, 1'b0);
        chk("arst o_data", o_data, 16'h0000);
        chk("arst line_cnt", o_line_cnt, 11'd0);
        @(negedge clk); href = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); href = ~href; data = 8'($urandom);
        end
        href = 1'b0;
        chk("post-arst writes", got_q.size(), 0);
        set_lines(3, 8);
        run_frame(3, 1'b1, 1'b0, 1'b1);
        check_frame("after arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture stage that sits directly upstream of `sync_fifo` in the OV7670 video path. It samples the OV7670 8-bit parallel bus (VSYNC/HREF/D[7:0]) on the camera pixel clock and frames the byte stream. It packs each byte pair into one 16-bit RGB565 pixel and pushes pixels into the FIFO write port, honouring the FIFO full flag. It also reports frame/line boundaries, dropped pixels and per-frame geometry to downstream control logic.

## Interface
- `H_ACTIVE`, default 640, expected pixels per line; used only for the `o_line_err` check.
- `V_ACTIVE`, default 480, expected lines per frame; used only for the `o_frame_err` check.
- `CW`, default 11, width of the pixel and line counters; must satisfy 2^CW > max(H_ACTIVE, V_ACTIVE).
- Clock and reset: one clock; reset is asynchronous and active-low. Ports `i_clk` / `i_rstn`.
- `i_clk` in 1: camera PCLK. Camera outputs launch on the falling edge and are sampled on the rising edge.
- `i_rstn` in 1: asynchronous active-low reset.
- `i_vsync` in 1: high = vertical blanking.
- `i_href` in 1: high = active byte on `i_data`.
- `i_data` in 8: camera byte.
- `i_en` in 1: capture enable. Sampled only at start of frame.
- `i_clr` in 1: one-cycle pulse that clears the sticky flags.
- `i_full` in 1: FIFO `o_full`.
- `o_wr` out 1: FIFO write strobe.
- `o_data` out 16: RGB565 pixel, {first byte, second byte}.
- `o_sof` out 1: start-of-frame pulse.
- `o_eof` out 1: end-of-frame pulse.
- `o_overflow` out 1: sticky; a pixel was dropped because of `i_full`.
- `o_line_err` out 1: sticky; a line had the wrong pixel count or an odd byte count.
- `o_frame_err` out 1: sticky; a frame had a line count different from V_ACTIVE.
- `o_line_cnt` out CW: lines completed in the current/last frame.
- `o_drop_cnt` out 16: dropped-pixel count (see Configuration).

## Operation
- States: S_SYNC, S_VBLANK, S_ACTIVE, S_SKIP. Reset state is S_SYNC.
- S_SYNC: ignore all input until `i_vsync`=1, then go to S_VBLANK. This prevents capturing a partial frame after reset.
- S_VBLANK: on a sampled `i_vsync` 1→0:
  - if `i_en`=1: go to S_ACTIVE, pulse `o_sof`, clear `o_line_cnt`;
  - else: go to S_SKIP.
- S_SKIP: no writes. On `i_vsync` 0→1, return to S_VBLANK. No `o_eof` is issued.
- S_ACTIVE, byte handling:
  - Each cycle with `i_href`=1 toggles the byte phase.
  - Phase 0 latches the high byte.
  - Phase 1 forms a pixel.
- S_ACTIVE, on `i_href` 1→0 (end of line):
  - `o_line_cnt` += 1 (saturates at all-ones).
  - Pixel counter and byte phase reset.
  - A lone phase-0 byte is discarded.
  - If the odd byte was discarded or pixel count ≠ H_ACTIVE: set `o_line_err`.
- S_ACTIVE, on `i_vsync` 0→1 (end of frame):
  - Pulse `o_eof`; go to S_VBLANK.
  - If `o_line_cnt` ≠ V_ACTIVE: set `o_frame_err`.
  - An `i_href` still high at that edge is treated as an end of line in the same cycle.
- `i_en` deasserted mid-frame: the current frame completes normally. It takes effect at the next start of frame.
- Pixel write when `i_full`=1 (sampled on the same edge as the second byte):
  - no `o_wr`;
  - pixel dropped;
  - `o_overflow` set;
  - drop counter += 1.
  - Pixel counter still increments, so geometry checks stay valid.
- `i_clr` clears `o_overflow`, `o_line_err`, `o_frame_err` and `o_drop_cnt`. If `i_clr` and a new error occur in the same cycle, the error wins.
- Edge detection on `i_vsync`/`i_href` uses one registered copy of each input, reset to 0.

## Timing
- Reset values:
  - `o_wr`=0, `o_data`=0;
  - `o_sof`=`o_eof`=0;
  - all sticky flags = 0;
  - `o_line_cnt`=0, `o_drop_cnt`=0;
  - state S_SYNC, byte phase 0.
- Pixel latency: second byte sampled on edge N. `o_wr`=1 and `o_data` are valid during cycle N+1; the FIFO captures them on edge N+1.
- `o_wr` is a single-cycle pulse. At most one write every 2 cycles. No backpressure to the camera exists.
- `o_sof` is high for exactly the one cycle after the edge that samples `i_vsync`=0 in S_VBLANK. `o_eof` behaves the same way for `i_vsync`=1 in S_ACTIVE.
- The first pixel's `o_wr` is never earlier than the cycle after `o_sof`.
- The `o_line_cnt` update is visible one cycle after the sampled `i_href` falling edge.
- Async reset mid-line: all outputs go to reset values immediately, with no partial write. Capture resumes only after a full vblank.

## Configuration
- `OV7670_CAPTURE_DROP_CNT_EN` defined: `o_drop_cnt` is a 16-bit counter of dropped pixels. It saturates at 16'hFFFF and is cleared by `i_clr` or reset.
- Not defined: the counter logic is omitted and `o_drop_cnt` is tied to 0. `o_overflow` behaviour is unchanged.

## Test plan
- Nominal frame:
  - Stimulus: H_ACTIVE=4, V_ACTIVE=3, `i_en`=1, vsync pulse, then 3 lines of 8 bytes 8'h00..8'h07.
  - Response: 12 writes with `o_data` 16'h0001, 16'h0203, 16'h0405, 16'h0607 per line; `o_sof` once and `o_eof` once; `o_line_cnt`=3; no error flags set.
- Backpressure:
  - Stimulus: `i_full`=1 across the 2nd and 3rd pixel of line 0.
  - Response: 10 writes; `o_overflow`=1; `o_drop_cnt`=2 with the macro defined (0 without); `o_line_err`=0.
- Odd/short line:
  - Stimulus: line 1 has 7 bytes.
  - Response: 3 writes for that line; last byte discarded; `o_line_err`=1; `i_clr` pulse returns it to 0.
- Reset mid-frame:
  - Stimulus: release reset with `i_vsync`=0 and `i_href` toggling.
  - Response: zero writes until a vsync high→low is seen; an async reset asserted mid-line forces `o_wr`=0 in the same cycle.
- Enable gating:
  - Stimulus: `i_en`=0 at SOF.
  - Response: the whole frame is skipped, with no `o_sof`/`o_eof`.
  - Stimulus: `i_en` dropped after SOF.
  - Response: the frame completes with all 12 writes.
- Wrong line count:
  - Stimulus: 2 lines, then vsync rises.
  - Response: `o_eof` pulse; `o_line_cnt`=2; `o_frame_err`=1.
